// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: fixed LATENCY-cycle word fetch with fault flagging and a load port.
// No backpressure path: one fetch in flight, en sampled only in IDLE; busy covers WAIT and RESP.
module inst_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0040_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] addr,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        busy,
  output logic        addr_fault
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [31:0]       addr_q, addr_nxt;
  logic              resp_load;

  logic [31:0]       mem [DEPTH_WORDS];

  logic [31:0]       fetch_addr, fetch_off, load_off;
  logic              fetch_ok, load_ok;
  logic [IDX_W-1:0]  fetch_idx, load_idx;

  // With LATENCY=1 RESP is entered straight from IDLE, so the live address is the one to decode.
  assign fetch_addr = (state == IDLE) ? addr : addr_q;
  assign fetch_off  = fetch_addr - BASE_ADDR;
  assign fetch_ok   = (fetch_off < SPAN_BYTES) && (fetch_addr[1:0] == 2'b00);
  assign fetch_idx  = fetch_off[IDX_W+1:2];

  assign load_off   = load_addr - BASE_ADDR;
  assign load_ok    = (load_off < SPAN_BYTES) && (load_addr[1:0] == 2'b00);
  assign load_idx   = load_off[IDX_W+1:2];

  assign busy       = (state != IDLE);
  assign inst_valid = (state == RESP);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr_q;
    resp_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) begin
          addr_nxt = addr;
          cnt_nxt  = CNT_INIT;
          if (LATENCY == 1) begin
            state_nxt = RESP;
            resp_load = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          resp_load = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= 32'h0;
      inst       <= 32'h0;
      addr_fault <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      addr_q <= addr_nxt;
      // Read and load share the edge; the non-blocking write makes this read-before-write.
      if (resp_load) begin
        addr_fault <= ~fetch_ok;
        inst       <= fetch_ok ? mem[fetch_idx] : 32'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_en && load_ok) mem[load_idx] <= load_data;
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: scoreboard of expected responses, LATENCY=3 and LATENCY=1 builds.
module tb_inst_mem_responder;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam int          LAT  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, load_en;
  logic [31:0] addr, load_addr, load_data;
  logic [31:0] inst;
  logic        inst_valid, busy, addr_fault;

  logic        en1, load_en1;
  logic [31:0] addr1, load_addr1, load_data1;
  logic [31:0] inst1;
  logic        inst_valid1, busy1, addr_fault1;

  typedef struct {
    logic [31:0] inst;
    logic        fault;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   n_valid = 0;
  logic prev_v  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inst_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .en(en), .addr(addr),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .inst(inst), .inst_valid(inst_valid), .busy(busy), .addr_fault(addr_fault)
  );

  inst_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .en(en1), .addr(addr1),
    .load_en(load_en1), .load_addr(load_addr1), .load_data(load_data1),
    .inst(inst1), .inst_valid(inst_valid1), .busy(busy1), .addr_fault(addr_fault1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (inst_valid === 1'b1) begin
      n_valid++;
      chk("valid_one_cycle", {31'b0, prev_v}, 32'h0);
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_valid: observed=1 expected=no response (inst=%h)", inst);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("inst", inst, e.inst);
        chk("addr_fault", {31'b0, addr_fault}, {31'b0, e.fault});
        chk("latency", 32'(cyc - e.acc), 32'(LAT - 1));
      end
    end
    prev_v <= inst_valid;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  // Leaves en high so back-to-back calls model a requester holding en.
  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ef,
                       input bit push, output int acc);
    int n = 0;
    while (busy === 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    assert (n < 20) else begin
      errors++;
      $error("FAIL idle_timeout: observed busy=%b expected=0", busy);
    end
    addr = a; en = 1'b1;
    step();
    acc = cyc;
    if (push) sb.push_back('{ei, ef, cyc});
    chk("busy_after_accept", {31'b0, busy}, 32'h1);
  endtask

  task automatic drain();
    int n = 0;
    en = 1'b0;
    while ((sb.size() != 0 || busy === 1'b1) && n < 30) begin
      step();
      n++;
    end
    checks++;
    assert (n < 30) else begin
      errors++;
      $error("FAIL drain_timeout: observed pending=%0d expected=0", sb.size());
    end
  endtask

  initial begin
    int a0, a1, a2, nv;
    reset = 1'b1; en = 1'b0; addr = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
    en1 = 1'b0; addr1 = '0; load_en1 = 1'b0; load_addr1 = '0; load_data1 = '0;
    step(2);
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_fault", {31'b0, addr_fault}, 32'h0);
    reset = 1'b0;
    step();

    // Basic fetch of word 0
    load(BASE, 32'h2408_000A);
    fetch(BASE, 32'h2408_000A, 1'b0, 1'b1, a0);
    drain();

    // Fault cases and the last in-range word
    fetch(BASE + 32'd2, 32'h0, 1'b1, 1'b1, a0);
    drain();
    load(BASE + 32'h3FC, 32'hCAFE_F00D);
    fetch(BASE + 32'h3FC, 32'hCAFE_F00D, 1'b0, 1'b1, a0);
    drain();
    fetch(32'h003F_FFFC, 32'h0, 1'b1, 1'b1, a0);
    drain();
    fetch(32'h0040_0400, 32'h0, 1'b1, 1'b1, a0);
    drain();

    // Misaligned and out-of-range loads are dropped
    load(BASE + 32'd1, 32'hFFFF_FFFF);
    load(BASE + 32'h400, 32'hFFFF_FFFF);
    fetch(BASE, 32'h2408_000A, 1'b0, 1'b1, a0);
    drain();

    // en held high: one accept per LAT+1 cycles
    load(BASE + 32'd4,  32'h0000_0001);
    load(BASE + 32'd8,  32'h0000_0002);
    load(BASE + 32'd12, 32'h0000_0003);
    fetch(BASE + 32'd4,  32'h0000_0001, 1'b0, 1'b1, a0);
    fetch(BASE + 32'd8,  32'h0000_0002, 1'b0, 1'b1, a1);
    fetch(BASE + 32'd12, 32'h0000_0003, 1'b0, 1'b1, a2);
    drain();
    chk("spacing_0_1", 32'(a1 - a0), 32'(LAT + 1));
    chk("spacing_1_2", 32'(a2 - a1), 32'(LAT + 1));

    // Reset during WAIT aborts the fetch
    fetch(BASE + 32'd4, 32'h0, 1'b0, 1'b0, a0);
    en = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_inst", inst, 32'h0);
    chk("midrst_valid", {31'b0, inst_valid}, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_fault", {31'b0, addr_fault}, 32'h0);
    step(2);
    reset = 1'b0;
    nv = n_valid;
    step(8);
    chk("no_resp_after_reset", 32'(n_valid), 32'(nv));
    fetch(BASE + 32'd4, 32'h0000_0001, 1'b0, 1'b1, a0);
    drain();

    // Load collides with the fetch at RESP entry: old word returned
    load(BASE + 32'd20, 32'h1111_1111);
    fetch(BASE + 32'd20, 32'h1111_1111, 1'b0, 1'b1, a0);
    en = 1'b0;
    step();
    load(BASE + 32'd20, 32'hDEAD_BEEF);
    drain();
    fetch(BASE + 32'd20, 32'hDEAD_BEEF, 1'b0, 1'b1, a0);
    drain();

    // LATENCY=1 build
    load_en1 = 1'b1; load_addr1 = BASE; load_data1 = 32'h3C01_1001;
    step();
    load_en1 = 1'b0;
    en1 = 1'b1; addr1 = BASE;
    step();
    en1 = 1'b0;
    chk("l1_valid", {31'b0, inst_valid1}, 32'h1);
    chk("l1_busy", {31'b0, busy1}, 32'h1);
    chk("l1_inst", inst1, 32'h3C01_1001);
    chk("l1_fault", {31'b0, addr_fault1}, 32'h0);
    step();
    chk("l1_valid_drop", {31'b0, inst_valid1}, 32'h0);
    chk("l1_busy_drop", {31'b0, busy1}, 32'h0);
    en1 = 1'b1; addr1 = BASE + 32'd2;
    step();
    en1 = 1'b0;
    chk("l1_mis_valid", {31'b0, inst_valid1}, 32'h1);
    chk("l1_mis_fault", {31'b0, addr_fault1}, 32'h1);
    chk("l1_mis_inst", inst1, 32'h0);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
Instruction-memory responder sitting on the far side of the PC fetch interface. It accepts a fetch request (enable + byte address) from the PC stage, performs a fixed multi-cycle word read from an internal instruction array, and returns the instruction with a one-cycle valid strobe. It also flags misaligned and out-of-range fetches, and provides a load port so the bench or a boot loader can fill the array.

Parameters:
BASE_ADDR, 32'h00400000, byte address of word 0 of the array (MIPS text base)
DEPTH_WORDS, 256, number of 32-bit words in the array; power of two
LATENCY, 3, cycles from request accept to inst_valid; legal range 1..15

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  fetch request; sampled only in IDLE
addr  input  32  fetch byte address, sampled with en
load_en  input  1  array write strobe
load_addr  input  32  byte address for load write; same mapping as addr
load_data  input  32  word written when load_en=1
inst  output  32  fetched instruction, held until next response
inst_valid  output  1  one-cycle strobe: inst/addr_fault are valid
busy  output  1  high whenever state != IDLE
addr_fault  output  1  qualified by inst_valid: misaligned or out-of-range fetch

Behaviour:
- Reset (async, while reset=1): state=IDLE, latency counter=0, captured address=0, inst=32'h0, inst_valid=0, addr_fault=0, busy=0. Array contents are NOT reset.
- Reset mid-operation aborts the outstanding fetch; no response is issued after reset deasserts.
- Address mapping: offset = addr - BASE_ADDR, 32-bit unsigned modulo 2^32. In range iff offset < DEPTH_WORDS*4. Word index = offset[log2(DEPTH_WORDS)+1:2]. Misaligned iff addr[1:0] != 0. Addresses below BASE_ADDR wrap to large offsets and are out of range.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if en=1 at a rising edge, capture addr and load the counter with LATENCY-1. Go to RESP if LATENCY=1, otherwise go to WAIT.
  - WAIT: decrement the counter each edge. When the counter equals 1, go to RESP on the next edge.
  - RESP: inst_valid=1 for exactly this cycle, then go to IDLE. en is ignored while in RESP.
- Latency: a request accepted at edge N gives inst_valid=1 in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after accept. The next request can be accepted at the edge that leaves RESP+1, i.e. in IDLE.
- Response data: inst and addr_fault are registered on the edge entering RESP.
  - Fault case (misaligned or out of range): addr_fault=1 and inst=32'h00000000 (NOP). The array is not read.
  - Good case: addr_fault=0 and inst=array[index].
  - inst and addr_fault hold their values until the next RESP entry.
- busy is combinational from the state: 1 in WAIT and RESP, 0 in IDLE.
- Load port: when load_en=1 and load_addr is in range and aligned, write array[index] at the rising edge, in any state. Invalid load addresses are silently dropped.
- Simultaneous load and fetch to the same word at the RESP-entry edge: read-before-write. The fetch returns the old word; the new word is visible to later fetches.
- en held high continuously: one fetch per LATENCY+1 cycles, addresses sampled only in IDLE.

Test Plan:
1. Reset then load word 0 with 32'h2408000A. Fetch addr=32'h00400000 with LATENCY=3 -> busy rises the cycle after accept; inst_valid=1 exactly 3 cycles after the accept edge, inst=32'h2408000A, addr_fault=0; inst_valid low the next cycle.
2. Fetch 32'h00400002 -> inst_valid with addr_fault=1, inst=32'h0. Fetch 32'h003FFFFC (below base) -> addr_fault=1. Fetch 32'h00400400 (first word past DEPTH 256) -> addr_fault=1.
3. Hold en=1 with addr stepping +4 each accept over words preloaded 1,2,3 -> responses 1,2,3 in order, spaced 4 cycles apart; no request accepted while busy=1.
4. Assert reset during WAIT after accepting 32'h00400004 -> outputs go to zero immediately; no inst_valid after release; the next fetch behaves normally.
5. At the RESP-entry edge, load word 5 with 32'hDEADBEEF while fetching word 5 (old value 32'h11111111) -> inst=32'h11111111; a following fetch of word 5 returns 32'hDEADBEEF.
6. LATENCY=1 build: accept at edge N -> inst_valid high in the cycle after edge N; busy high for exactly 1 cycle.
